// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 step generator and step monitor:
// phase codes, sector lookup table, monitor state encoding.
package motoro3_pkg;

    localparam logic [3:0] PH_OFF = 4'h0;
    localparam logic [3:0] PH_LO  = 4'h1;
    localparam logic [3:0] PH_HI  = 4'h2;

    localparam logic [2:0] SECT_NONE = 3'd7;

    // Index = sector; each entry is {A, B, C}.
    localparam logic [5:0][11:0] SECT_TBL = {
        {PH_OFF, PH_LO,  PH_HI },
        {PH_LO,  PH_OFF, PH_HI },
        {PH_LO,  PH_HI,  PH_OFF},
        {PH_OFF, PH_HI,  PH_LO },
        {PH_HI,  PH_OFF, PH_LO },
        {PH_HI,  PH_LO,  PH_OFF}
    };

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    function automatic logic ph_legal(input logic [3:0] code);
        return (code == PH_OFF) || (code == PH_LO) || (code == PH_HI);
    endfunction

    // Forward distance from one sector to another, modulo 6 (both inputs 0..5).
    function automatic logic [2:0] sect_delta(input logic [2:0] from, input logic [2:0] to);
        logic [3:0] d;
        d = {1'b0, to} + 4'd6 - {1'b0, from};
        if (d >= 4'd6)
            d = d - 4'd6;
        return d[2:0];
    endfunction

endpackage

// File: rtl/motoro3_sector_decode.sv
// Combinational decode of the three phase codes into a commutation sector.
// Zero latency; no backpressure. Shoot-through takes priority over idle/illegal.
module motoro3_sector_decode
    import motoro3_pkg::*;
(
    input  logic [3:0] step_a,
    input  logic [3:0] step_b,
    input  logic [3:0] step_c,
    output logic [2:0] sector,
    output logic       idle,
    output logic       illegal,
    output logic       shoot
);

    always_comb begin
        sector  = SECT_NONE;
        idle    = 1'b0;
        illegal = 1'b0;
        shoot   = !ph_legal(step_a) || !ph_legal(step_b) || !ph_legal(step_c);
        if (!shoot) begin
            if (step_a == PH_OFF && step_b == PH_OFF && step_c == PH_OFF) begin
                idle = 1'b1;
            end else begin
                illegal = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    if ({step_a, step_b, step_c} == SECT_TBL[i]) begin
                        sector  = 3'(i);
                        illegal = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/motoro3_step_monitor.sv
// Independent check on the drive path: sector, direction, step period, stall and faults.
// Latency 2 clk pin-to-output; no backpressure. Revolution counter built only with M3MON_REVCNT_EN.
module motoro3_step_monitor
    import motoro3_pkg::*;
#(
    parameter int CNT_W     = 25,
    parameter int STALL_CYC = 10_000_000
`ifdef M3MON_REVCNT_EN
    ,
    parameter int REV_W     = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       m3stepA,
    input  logic [3:0]       m3stepB,
    input  logic [3:0]       m3stepC,
    input  logic             m3faultClr,
    output logic [2:0]       m3sector,
    output logic             m3dir,
    output logic             m3running,
    output logic [CNT_W-1:0] m3period,
    output logic             m3periodVld,
    output logic             m3stall,
    output logic             m3faultShoot,
    output logic             m3faultSeq
`ifdef M3MON_REVCNT_EN
    ,
    output logic [REV_W-1:0] m3revCnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_CYC - 1);

    logic [3:0]       step_a_q, step_b_q, step_c_q;
    logic             clr_q;
    logic [2:0]       dec_sector;
    logic             dec_idle, dec_illegal, dec_shoot;
    logic [2:0]       delta;

    state_t           state_q, state_d;
    logic [2:0]       sector_q, sector_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             vld_q, vld_d;
    logic             stall_q, stall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fshoot_q, fshoot_d;
    logic             fseq_q, fseq_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_a_q <= PH_OFF;
            step_b_q <= PH_OFF;
            step_c_q <= PH_OFF;
            clr_q    <= 1'b0;
        end else begin
            step_a_q <= m3stepA;
            step_b_q <= m3stepB;
            step_c_q <= m3stepC;
            clr_q    <= m3faultClr;
        end
    end

    motoro3_sector_decode u_decode (
        .step_a  (step_a_q),
        .step_b  (step_b_q),
        .step_c  (step_c_q),
        .sector  (dec_sector),
        .idle    (dec_idle),
        .illegal (dec_illegal),
        .shoot   (dec_shoot)
    );

    always_comb begin
        state_d  = state_q;
        sector_d = sector_q;
        dir_d    = dir_q;
        period_d = period_q;
        vld_d    = 1'b0;
        stall_d  = stall_q;
        cnt_d    = cnt_q;
        fshoot_d = fshoot_q;
        fseq_d   = fseq_q;
        delta    = sect_delta(sector_q, dec_sector);
        case (state_q)
            IDLE: begin
                if (dec_shoot || dec_illegal) begin
                    state_d  = FAULT;
                    fshoot_d = fshoot_q | dec_shoot;
                    fseq_d   = fseq_q | dec_illegal;
                end else if (!dec_idle) begin
                    state_d  = RUN;
                    sector_d = dec_sector;
                    cnt_d    = '0;
                    stall_d  = 1'b0;
                end else begin
                    sector_d = SECT_NONE;
                end
            end
            RUN: begin
                if (dec_shoot || dec_illegal) begin
                    state_d  = FAULT;
                    fshoot_d = fshoot_q | dec_shoot;
                    fseq_d   = fseq_q | dec_illegal;
                    cnt_d    = '0;
                    stall_d  = 1'b0;
                end else if (dec_idle) begin
                    state_d  = IDLE;
                    sector_d = SECT_NONE;
                    cnt_d    = '0;
                    stall_d  = 1'b0;
                end else if (dec_sector == sector_q) begin
                    if (cnt_q == STALL_LAST)
                        stall_d = 1'b1;
                    if (cnt_q != CNT_MAX)
                        cnt_d = cnt_q + 1'b1;
                end else if (delta == 3'd1 || delta == 3'd5) begin
                    sector_d = dec_sector;
                    dir_d    = (delta == 3'd1);
                    period_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
                    vld_d    = 1'b1;
                    cnt_d    = '0;
                    stall_d  = 1'b0;
                end else begin
                    // Skipped sector: the previous sector stays visible for diagnosis.
                    state_d  = FAULT;
                    fseq_d   = 1'b1;
                    cnt_d    = '0;
                    stall_d  = 1'b0;
                end
            end
            FAULT: begin
                if (clr_q && dec_idle) begin
                    state_d  = IDLE;
                    sector_d = SECT_NONE;
                    fshoot_d = 1'b0;
                    fseq_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sector_q <= SECT_NONE;
            dir_q    <= 1'b1;
            period_q <= '0;
            vld_q    <= 1'b0;
            stall_q  <= 1'b0;
            cnt_q    <= '0;
            fshoot_q <= 1'b0;
            fseq_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sector_q <= sector_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            stall_q  <= stall_d;
            cnt_q    <= cnt_d;
            fshoot_q <= fshoot_d;
            fseq_q   <= fseq_d;
        end
    end

`ifdef M3MON_REVCNT_EN
    logic [REV_W-1:0] rev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rev_q <= '0;
        else if (vld_d && sector_q == 3'd5 && dec_sector == 3'd0)
            rev_q <= rev_q + 1'b1;
        else if (vld_d && sector_q == 3'd0 && dec_sector == 3'd5)
            rev_q <= rev_q - 1'b1;
    end

    assign m3revCnt = rev_q;
`endif

    assign m3sector     = sector_q;
    assign m3dir        = dir_q;
    assign m3running    = (state_q == RUN);
    assign m3period     = period_q;
    assign m3periodVld  = vld_q;
    assign m3stall      = stall_q;
    assign m3faultShoot = fshoot_q;
    assign m3faultSeq   = fseq_q;

endmodule

// File: tb/tb_motoro3_step_monitor.sv
// Directed bench for motoro3_step_monitor; stall threshold shortened to 100 cycles.
module tb_motoro3_step_monitor;

    logic        clk;
    logic        rst;
    logic [3:0]  m3stepA, m3stepB, m3stepC;
    logic        m3faultClr;
    logic [2:0]  m3sector;
    logic        m3dir, m3running, m3periodVld, m3stall, m3faultShoot, m3faultSeq;
    logic [24:0] m3period;
`ifdef M3MON_REVCNT_EN
    logic [15:0] m3revCnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    motoro3_step_monitor #(.CNT_W(25), .STALL_CYC(100)) dut (
        .clk          (clk),
        .rst          (rst),
        .m3stepA      (m3stepA),
        .m3stepB      (m3stepB),
        .m3stepC      (m3stepC),
        .m3faultClr   (m3faultClr),
        .m3sector     (m3sector),
        .m3dir        (m3dir),
        .m3running    (m3running),
        .m3period     (m3period),
        .m3periodVld  (m3periodVld),
        .m3stall      (m3stall),
        .m3faultShoot (m3faultShoot),
        .m3faultSeq   (m3faultSeq)
`ifdef M3MON_REVCNT_EN
        ,
        .m3revCnt     (m3revCnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sector table written out independently: {A,B,C} with OFF=0, LO=1, HI=2.
    task automatic drive_sector(input int s);
        case (s)
            0: {m3stepA, m3stepB, m3stepC} = {4'h2, 4'h1, 4'h0};
            1: {m3stepA, m3stepB, m3stepC} = {4'h2, 4'h0, 4'h1};
            2: {m3stepA, m3stepB, m3stepC} = {4'h0, 4'h2, 4'h1};
            3: {m3stepA, m3stepB, m3stepC} = {4'h1, 4'h2, 4'h0};
            4: {m3stepA, m3stepB, m3stepC} = {4'h1, 4'h0, 4'h2};
            5: {m3stepA, m3stepB, m3stepC} = {4'h0, 4'h1, 4'h2};
            default: {m3stepA, m3stepB, m3stepC} = 12'h000;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m3faultClr = 1'b0;
        drive_sector(7);
        tick(2);
        n_checks++;
        if ({m3sector, m3dir, m3running, m3periodVld, m3stall, m3faultShoot, m3faultSeq} !== 9'b111_1_0_0_0_0_0) begin
            n_fail++;
            $display("FAIL reset_flags: got sect=%0d dir=%b run=%b vld=%b stall=%b fs=%b fq=%b, expected 7 1 0 0 0 0 0",
                     m3sector, m3dir, m3running, m3periodVld, m3stall, m3faultShoot, m3faultSeq);
        end
        n_checks++;
        if (m3period !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_period: got %0d expected 0", m3period);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_forward();
        drive_sector(0);
        tick(2);
        n_checks++;
        if ({m3running, m3sector, m3periodVld} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL fwd_enter: got run=%b sect=%0d vld=%b expected 1 0 0", m3running, m3sector, m3periodVld);
        end
        tick(998);
        for (int i = 1; i <= 6; i++) begin
            drive_sector(i % 6);
            tick(2);
            n_checks++;
            if ({m3periodVld, m3dir, m3sector, m3stall} !== {1'b1, 1'b1, 3'(i % 6), 1'b0}) begin
                n_fail++;
                $display("FAIL fwd_step%0d: got vld=%b dir=%b sect=%0d stall=%b expected 1 1 %0d 0",
                         i, m3periodVld, m3dir, m3sector, m3stall, i % 6);
            end
            n_checks++;
            if (m3period !== 25'd1000) begin
                n_fail++;
                $display("FAIL fwd_period%0d: got %0d expected 1000", i, m3period);
            end
            tick(998);
        end
`ifdef M3MON_REVCNT_EN
        n_checks++;
        if (m3revCnt !== 16'd1) begin
            n_fail++;
            $display("FAIL fwd_revcnt: got %0d expected 1", m3revCnt);
        end
`endif
    endtask

    task automatic test_reverse();
        drive_sector(7);
        tick(2);
        n_checks++;
        if ({m3running, m3sector, m3periodVld} !== {1'b0, 3'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL rev_idle: got run=%b sect=%0d vld=%b expected 0 7 0", m3running, m3sector, m3periodVld);
        end
        drive_sector(2);
        tick(2);
        n_checks++;
        if ({m3running, m3sector, m3periodVld} !== {1'b1, 3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL rev_enter: got run=%b sect=%0d vld=%b expected 1 2 0", m3running, m3sector, m3periodVld);
        end
        tick(498);
        for (int s = 1; s >= -1; s--) begin
            drive_sector((s + 6) % 6);
            tick(2);
            n_checks++;
            if ({m3periodVld, m3dir, m3sector} !== {1'b1, 1'b0, 3'((s + 6) % 6)} || m3period !== 25'd500) begin
                n_fail++;
                $display("FAIL rev_step%0d: got vld=%b dir=%b sect=%0d period=%0d expected 1 0 %0d 500",
                         (s + 6) % 6, m3periodVld, m3dir, m3sector, m3period, (s + 6) % 6);
            end
`ifdef M3MON_REVCNT_EN
            n_checks++;
            if (m3revCnt !== ((s < 0) ? 16'd0 : 16'd1)) begin
                n_fail++;
                $display("FAIL rev_revcnt%0d: got %0d expected %0d", (s + 6) % 6, m3revCnt, (s < 0) ? 0 : 1);
            end
`endif
            tick(498);
        end
    endtask

    task automatic test_shoot();
        m3stepA = 4'h3;
        tick(1);
        n_checks++;
        if ({m3faultShoot, m3running} !== 2'b01) begin
            n_fail++;
            $display("FAIL shoot_early: got fs=%b run=%b expected 0 1", m3faultShoot, m3running);
        end
        tick(1);
        n_checks++;
        if ({m3faultShoot, m3running, m3sector, m3periodVld} !== {1'b1, 1'b0, 3'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL shoot_fault: got fs=%b run=%b sect=%0d vld=%b expected 1 0 5 0",
                     m3faultShoot, m3running, m3sector, m3periodVld);
        end
        m3faultClr = 1'b1;
        tick(1);
        m3faultClr = 1'b0;
        tick(2);
        n_checks++;
        if ({m3faultShoot, m3running} !== 2'b10) begin
            n_fail++;
            $display("FAIL shoot_clr_ignored: got fs=%b run=%b expected 1 0", m3faultShoot, m3running);
        end
        drive_sector(7);
        tick(3);
        n_checks++;
        if ({m3faultShoot, m3running, m3sector} !== {1'b1, 1'b0, 3'd5}) begin
            n_fail++;
            $display("FAIL shoot_off_noclr: got fs=%b run=%b sect=%0d expected 1 0 5", m3faultShoot, m3running, m3sector);
        end
        m3faultClr = 1'b1;
        tick(1);
        m3faultClr = 1'b0;
        tick(1);
        n_checks++;
        if ({m3faultShoot, m3faultSeq, m3running, m3sector} !== {1'b0, 1'b0, 1'b0, 3'd7}) begin
            n_fail++;
            $display("FAIL shoot_cleared: got fs=%b fq=%b run=%b sect=%0d expected 0 0 0 7",
                     m3faultShoot, m3faultSeq, m3running, m3sector);
        end
    endtask

    task automatic test_skip();
        drive_sector(1);
        tick(2);
        n_checks++;
        if ({m3running, m3sector} !== {1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL skip_enter: got run=%b sect=%0d expected 1 1", m3running, m3sector);
        end
        tick(18);
        drive_sector(4);
        tick(2);
        n_checks++;
        if ({m3faultSeq, m3faultShoot, m3periodVld, m3running, m3sector} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL skip_fault: got fq=%b fs=%b vld=%b run=%b sect=%0d expected 1 0 0 0 1",
                     m3faultSeq, m3faultShoot, m3periodVld, m3running, m3sector);
        end
        drive_sector(7);
        m3faultClr = 1'b1;
        tick(1);
        m3faultClr = 1'b0;
        tick(1);
        n_checks++;
        if ({m3faultSeq, m3running, m3sector} !== {1'b0, 1'b0, 3'd7}) begin
            n_fail++;
            $display("FAIL skip_cleared: got fq=%b run=%b sect=%0d expected 0 0 7", m3faultSeq, m3running, m3sector);
        end
    endtask

    task automatic test_stall();
        drive_sector(3);
        tick(2);
        tick(99);
        n_checks++;
        if ({m3stall, m3running} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_early: got stall=%b run=%b expected 0 1", m3stall, m3running);
        end
        tick(1);
        n_checks++;
        if ({m3stall, m3running} !== 2'b11) begin
            n_fail++;
            $display("FAIL stall_set: got stall=%b run=%b expected 1 1", m3stall, m3running);
        end
        tick(48);
        drive_sector(4);
        tick(2);
        n_checks++;
        if ({m3stall, m3periodVld, m3dir, m3sector} !== {1'b0, 1'b1, 1'b1, 3'd4} || m3period !== 25'd150) begin
            n_fail++;
            $display("FAIL stall_release: got stall=%b vld=%b dir=%b sect=%0d period=%0d expected 0 1 1 4 150",
                     m3stall, m3periodVld, m3dir, m3sector, m3period);
        end
    endtask

    task automatic test_reset_midrun();
        drive_sector(3);
        tick(2);
        n_checks++;
        if ({m3periodVld, m3dir, m3sector} !== {1'b1, 1'b0, 3'd3}) begin
            n_fail++;
            $display("FAIL midrun_rev: got vld=%b dir=%b sect=%0d expected 1 0 3", m3periodVld, m3dir, m3sector);
        end
        tick(8);
        drive_sector(2);
        tick(10);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({m3sector, m3dir, m3running, m3periodVld, m3stall, m3faultShoot, m3faultSeq} !== 9'b111_1_0_0_0_0_0
            || m3period !== 25'd0) begin
            n_fail++;
            $display("FAIL midrun_async: got sect=%0d dir=%b run=%b vld=%b stall=%b fs=%b fq=%b period=%0d expected 7 1 0 0 0 0 0 0",
                     m3sector, m3dir, m3running, m3periodVld, m3stall, m3faultShoot, m3faultSeq, m3period);
        end
`ifdef M3MON_REVCNT_EN
        n_checks++;
        if (m3revCnt !== 16'd0) begin
            n_fail++;
            $display("FAIL midrun_revcnt: got %0d expected 0", m3revCnt);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        n_checks++;
        if (m3running !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_wait: got run=%b expected 0", m3running);
        end
        tick(1);
        n_checks++;
        if ({m3running, m3sector, m3periodVld} !== {1'b1, 3'd2, 1'b0} || m3period !== 25'd0) begin
            n_fail++;
            $display("FAIL midrun_restart: got run=%b sect=%0d vld=%b period=%0d expected 1 2 0 0",
                     m3running, m3sector, m3periodVld, m3period);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_shoot();
        test_skip();
        test_stall();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
